// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RV64I subset decode; one-edge latency from decode to EX.
// stall holds the stage and counts held cycles, flush (higher priority) loads a bubble.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [31:0] instr,
   input  logic [63:0] data1_in,
   input  logic [63:0] read2_in,
   input  logic [63:0] imme_in,
   input  logic        stall,
   input  logic        flush,
   output logic        ex_valid,
   output logic        ALUSrc,
   output logic [3:0]  ALUcontrol,
   output logic [63:0] data1,
   output logic [63:0] read2,
   output logic [63:0] imme,
   output logic [4:0]  rd,
   output logic        RegWrite,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        MemtoReg,
   output logic        Branch,
   output logic [1:0]  branch_type,
   output logic        illegal,
   output logic [15:0] stall_cnt
);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0100;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SGE = 4'b1000;
   localparam logic [3:0] ALU_XOR = 4'b1001;

   typedef struct packed {
      logic        ex_valid;
      logic        alu_src;
      logic [3:0]  alu_ctl;
      logic [63:0] data1;
      logic [63:0] read2;
      logic [63:0] imme;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        branch;
      logic [1:0]  branch_type;
   } ex_t;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       dec_ok;
   ex_t        dec;
   ex_t        ex_q;
   logic       illegal_q;
   logic [15:0] stall_cnt_q;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   always_comb begin
      dec_ok          = 1'b1;
      dec             = '0;
      dec.ex_valid    = 1'b1;
      dec.data1       = data1_in;
      dec.read2       = read2_in;
      dec.imme        = imme_in;
      dec.rd          = instr[11:7];
      case (opcode)
         7'b0110011: begin
            dec.reg_write = 1'b1;
            case (funct3)
               3'b000: begin
                  if (funct7 == 7'b0000000)      dec.alu_ctl = ALU_ADD;
                  else if (funct7 == 7'b0100000) dec.alu_ctl = ALU_SUB;
                  else                           dec_ok = 1'b0;
               end
               3'b001:  dec.alu_ctl = ALU_SLL;
               3'b010:  dec.alu_ctl = ALU_SLT;
               3'b100:  dec.alu_ctl = ALU_XOR;
               3'b110:  dec.alu_ctl = ALU_OR;
               3'b111:  dec.alu_ctl = ALU_AND;
               default: dec_ok = 1'b0;
            endcase
         end
         7'b0010011: begin
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            case (funct3)
               3'b000:  dec.alu_ctl = ALU_ADD;
               3'b001: begin
                  // RV64 shamt is 6 bits; any set bit above it is not slli
                  if (instr[31:26] == 6'd0) dec.alu_ctl = ALU_SLL;
                  else                      dec_ok = 1'b0;
               end
               3'b010:  dec.alu_ctl = ALU_SLT;
               3'b100:  dec.alu_ctl = ALU_XOR;
               3'b110:  dec.alu_ctl = ALU_OR;
               3'b111:  dec.alu_ctl = ALU_AND;
               default: dec_ok = 1'b0;
            endcase
         end
         7'b0000011: begin
            dec.alu_ctl    = ALU_ADD;
            dec.alu_src    = 1'b1;
            dec.mem_read   = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.reg_write  = 1'b1;
            if (funct3 != 3'b011) dec_ok = 1'b0;
         end
         7'b0100011: begin
            dec.alu_ctl   = ALU_ADD;
            dec.alu_src   = 1'b1;
            dec.mem_write = 1'b1;
            if (funct3 != 3'b011) dec_ok = 1'b0;
         end
         7'b1100011: begin
            dec.branch = 1'b1;
            case (funct3)
               3'b000: begin dec.alu_ctl = ALU_SUB; dec.branch_type = 2'b00; end
               3'b001: begin dec.alu_ctl = ALU_SUB; dec.branch_type = 2'b01; end
               3'b100: begin dec.alu_ctl = ALU_SLT; dec.branch_type = 2'b10; end
               3'b101: begin dec.alu_ctl = ALU_SGE; dec.branch_type = 2'b11; end
               default: dec_ok = 1'b0;
            endcase
         end
         default: dec_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q        <= '0;
         illegal_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         illegal_q <= 1'b0;
         if (stall && !flush && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
         if (flush) begin
            ex_q <= '0;
         end else if (!stall) begin
            if (id_valid && dec_ok) begin
               ex_q <= dec;
            end else begin
               ex_q      <= '0;
               illegal_q <= id_valid;
            end
         end
      end
   end

   assign ex_valid    = ex_q.ex_valid;
   assign ALUSrc      = ex_q.alu_src;
   assign ALUcontrol  = ex_q.alu_ctl;
   assign data1       = ex_q.data1;
   assign read2       = ex_q.read2;
   assign imme        = ex_q.imme;
   assign rd          = ex_q.rd;
   assign RegWrite    = ex_q.reg_write;
   assign MemRead     = ex_q.mem_read;
   assign MemWrite    = ex_q.mem_write;
   assign MemtoReg    = ex_q.mem_to_reg;
   assign Branch      = ex_q.branch;
   assign branch_type = ex_q.branch_type;
   assign illegal     = illegal_q;
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: decode vector table plus stall/flush/reset sequences.
module tb_id_ex_stage;

   typedef struct packed {
      logic        ex_valid;
      logic        alusrc;
      logic [3:0]  aluc;
      logic [63:0] data1;
      logic [63:0] read2;
      logic [63:0] imme;
      logic [4:0]  rd;
      logic        regw;
      logic        memr;
      logic        memw;
      logic        m2r;
      logic        br;
      logic [1:0]  bt;
      logic        illegal;
      logic [15:0] scnt;
   } out_t;

   typedef struct {
      logic        v;
      logic [31:0] instr;
      logic [63:0] d1;
      logic [63:0] r2;
      logic [63:0] im;
      out_t        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid = 1'b0;
   logic [31:0] instr = '0;
   logic [63:0] data1_in = '0, read2_in = '0, imme_in = '0;
   logic        stall = 1'b0, flush = 1'b0;
   logic        ex_valid, ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg, Branch, illegal;
   logic [3:0]  ALUcontrol;
   logic [63:0] data1, read2, imme;
   logic [4:0]  rd;
   logic [1:0]  branch_type;
   logic [15:0] stall_cnt;

   int   n_vec = 0;
   int   n_bad = 0;
   out_t sb[$];
   vec_t tbl[$];
   out_t held;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .instr(instr),
      .data1_in(data1_in), .read2_in(read2_in), .imme_in(imme_in),
      .stall(stall), .flush(flush), .ex_valid(ex_valid), .ALUSrc(ALUSrc),
      .ALUcontrol(ALUcontrol), .data1(data1), .read2(read2), .imme(imme),
      .rd(rd), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemtoReg(MemtoReg), .Branch(Branch), .branch_type(branch_type),
      .illegal(illegal), .stall_cnt(stall_cnt)
   );

   function automatic out_t sample();
      out_t o;
      o = '{ex_valid, ALUSrc, ALUcontrol, data1, read2, imme, rd, RegWrite,
            MemRead, MemWrite, MemtoReg, Branch, branch_type, illegal, stall_cnt};
      return o;
   endfunction

   task automatic check(input string name, input out_t exp);
      out_t act;
      act = sample();
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // bubble with a given stall count
   function automatic out_t bub(input logic [15:0] sc, input logic ill);
      out_t o;
      o = '0;
      o.scnt = sc;
      o.illegal = ill;
      return o;
   endfunction

   function automatic out_t live(input logic [3:0] alu, input logic src, input logic rw,
                                 input logic mr, input logic mw, input logic m2r,
                                 input logic br, input logic [1:0] bt, input logic [4:0] r,
                                 input logic [63:0] d1, input logic [63:0] r2,
                                 input logic [63:0] im, input logic [15:0] sc);
      out_t o;
      o = '{1'b1, src, alu, d1, r2, im, r, rw, mr, mw, m2r, br, bt, 1'b0, sc};
      return o;
   endfunction

   // drive one cycle's inputs, queue the expectation, compare after the edge
   task automatic step(input string name, input logic v, input logic [31:0] ins,
                       input logic [63:0] d1, input logic [63:0] r2, input logic [63:0] im,
                       input logic st, input logic fl, input out_t exp);
      out_t e;
      id_valid = v; instr = ins; data1_in = d1; read2_in = r2; imme_in = im;
      stall = st; flush = fl;
      sb.push_back(exp);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_vec++; n_bad++;
         $display("FAIL %s: scoreboard empty, got nothing want entry", name);
      end else begin
         e = sb.pop_front();
         check(name, e);
      end
   endtask

   task automatic add_vec(input logic v, input logic [31:0] ins, input logic ill,
                          input logic [3:0] alu, input logic src, input logic rw,
                          input logic mr, input logic mw, input logic m2r, input logic br,
                          input logic [1:0] bt, input logic [4:0] r);
      vec_t t;
      int   k;
      k = tbl.size();
      t.v = v; t.instr = ins;
      t.d1 = 64'h1000_0000_0000_0100 + 64'(k);
      t.r2 = 64'h2000_0000_0000_0200 + 64'(k);
      t.im = 64'hFFFF_FFFF_FFFF_FF00 + 64'(k);
      if (!v || ill) t.e = bub(16'd0, v && ill);
      else t.e = live(alu, src, rw, mr, mw, m2r, br, bt, r, t.d1, t.r2, t.im, 16'd0);
      tbl.push_back(t);
   endtask

   initial begin
      //      v  instr          ill alu     src rw mr mw m2r br bt     rd
      add_vec(1, 32'h0020_81B3, 0, 4'b0010, 0, 1, 0, 0, 0, 0, 2'b00, 5'd3);  // add
      add_vec(1, 32'h4020_82B3, 0, 4'b0110, 0, 1, 0, 0, 0, 0, 2'b00, 5'd5);  // sub
      add_vec(1, 32'h0020_9333, 0, 4'b0100, 0, 1, 0, 0, 0, 0, 2'b00, 5'd6);  // sll
      add_vec(1, 32'h0020_A3B3, 0, 4'b0111, 0, 1, 0, 0, 0, 0, 2'b00, 5'd7);  // slt
      add_vec(1, 32'h0020_C433, 0, 4'b1001, 0, 1, 0, 0, 0, 0, 2'b00, 5'd8);  // xor
      add_vec(1, 32'h0020_E4B3, 0, 4'b0001, 0, 1, 0, 0, 0, 0, 2'b00, 5'd9);  // or
      add_vec(1, 32'h0020_F533, 0, 4'b0000, 0, 1, 0, 0, 0, 0, 2'b00, 5'd10); // and
      add_vec(1, 32'h0050_8593, 0, 4'b0010, 1, 1, 0, 0, 0, 0, 2'b00, 5'd11); // addi
      add_vec(1, 32'h0030_9613, 0, 4'b0100, 1, 1, 0, 0, 0, 0, 2'b00, 5'd12); // slli
      add_vec(1, 32'h0400_9613, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0);  // slli bad shamt
      add_vec(1, 32'h0080_B683, 0, 4'b0010, 1, 1, 1, 0, 1, 0, 2'b00, 5'd13); // ld
      add_vec(1, 32'h0020_B423, 0, 4'b0010, 1, 0, 0, 1, 0, 0, 2'b00, 5'd8);  // sd
      add_vec(1, 32'h0020_8063, 0, 4'b0110, 0, 0, 0, 0, 0, 1, 2'b00, 5'd0);  // beq
      add_vec(1, 32'h0020_9063, 0, 4'b0110, 0, 0, 0, 0, 0, 1, 2'b01, 5'd0);  // bne
      add_vec(1, 32'h0020_C063, 0, 4'b0111, 0, 0, 0, 0, 0, 1, 2'b10, 5'd0);  // blt
      add_vec(1, 32'h0020_D063, 0, 4'b1000, 0, 0, 0, 0, 0, 1, 2'b11, 5'd0);  // bge
      add_vec(1, 32'h0000_007F, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0);  // bad opcode
      add_vec(1, 32'h0220_81B3, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0);  // mul
      add_vec(1, 32'h0020_B1B3, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0);  // sltu
      add_vec(1, 32'h0080_A683, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0);  // lw
      add_vec(0, 32'h0020_81B3, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0);  // no valid

      // reset state, held asynchronously
      #2;
      check("reset", bub(16'd0, 1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < tbl.size(); i++)
         step($sformatf("vec%0d", i), tbl[i].v, tbl[i].instr, tbl[i].d1, tbl[i].r2,
              tbl[i].im, 1'b0, 1'b0, tbl[i].e);

      step("add_example", 1, 32'h0020_81B3, 64'd5, 64'd7, 64'd99, 0, 0,
           live(4'b0010, 0, 1, 0, 0, 0, 0, 2'b00, 5'd3, 64'd5, 64'd7, 64'd99, 16'd0));

      // illegal pulse lasts one cycle only
      step("illegal_pulse", 1, 32'h0000_007F, 64'd1, 64'd2, 64'd3, 0, 0, bub(16'd0, 1'b1));
      step("illegal_clear", 0, 32'h0000_007F, 64'd1, 64'd2, 64'd3, 0, 0, bub(16'd0, 1'b0));

      // stall holds sub for three cycles while counting
      held = live(4'b0110, 0, 1, 0, 0, 0, 0, 2'b00, 5'd5, 64'hA, 64'hB, 64'hC, 16'd0);
      step("sub_load", 1, 32'h4020_82B3, 64'hA, 64'hB, 64'hC, 0, 0, held);
      for (int i = 1; i <= 3; i++) begin
         held.scnt = 16'(i);
         step($sformatf("stall%0d", i), 1, 32'h0020_F533, 64'h55, 64'h66, 64'h77, 1, 0, held);
      end
      // illegal under stall must not pulse
      held.scnt = 16'd4;
      step("stall_illegal", 1, 32'h0000_007F, 64'h0, 64'h0, 64'h0, 1, 0, held);
      step("stall_flush", 1, 32'h0020_81B3, 64'h1, 64'h2, 64'h3, 1, 1, bub(16'd4, 1'b0));
      step("flush_only", 1, 32'h0000_007F, 64'h1, 64'h2, 64'h3, 0, 1, bub(16'd4, 1'b0));

      // async reset between edges while a live instruction is held
      step("pre_reset", 1, 32'h0020_81B3, 64'd5, 64'd7, 64'd0, 0, 0,
           live(4'b0010, 0, 1, 0, 0, 0, 0, 2'b00, 5'd3, 64'd5, 64'd7, 64'd0, 16'd4));
      #2 rst_n = 1'b0;
      #1 check("async_reset", bub(16'd0, 1'b0));
      @(negedge clk);
      rst_n = 1'b1;

      // reset asserted mid-stall clears held state and counter
      step("sub_reload", 1, 32'h4020_82B3, 64'hA, 64'hB, 64'hC, 0, 0,
           live(4'b0110, 0, 1, 0, 0, 0, 0, 2'b00, 5'd5, 64'hA, 64'hB, 64'hC, 16'd0));
      step("stall_a", 1, 32'h4020_82B3, 64'h0, 64'h0, 64'h0, 1, 0,
           live(4'b0110, 0, 1, 0, 0, 0, 0, 2'b00, 5'd5, 64'hA, 64'hB, 64'hC, 16'd1));
      #2 rst_n = 1'b0;
      #1 check("reset_mid_stall", bub(16'd0, 1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      step("post_reset_decode", 1, 32'h0080_B683, 64'd8, 64'd9, 64'd16, 0, 0,
           live(4'b0010, 1, 1, 1, 0, 1, 0, 2'b00, 5'd13, 64'd8, 64'd9, 64'd16, 16'd0));

      // saturation of the stall counter
      stall = 1'b1; flush = 1'b0; id_valid = 1'b1; instr = 32'h0020_81B3;
      repeat (65540) @(posedge clk);
      #1;
      check("stall_saturate",
            live(4'b0010, 1, 1, 1, 0, 1, 0, 2'b00, 5'd13, 64'd8, 64'd9, 64'd16, 16'hFFFF));
      step("sat_flush", 1, 32'h0020_81B3, 64'd1, 64'd1, 64'd1, 1, 1, bub(16'hFFFF, 1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001: The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002: Ports, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode-stage instruction present
- instr  in  32  RV64I instruction word
- data1_in  in  64  register-file read port 1
- read2_in  in  64  register-file read port 2
- imme_in  in  64  sign-extended immediate from the immediate generator
- stall  in  1  hold the EX stage contents
- flush  in  1  squash the EX stage contents
- ex_valid  out  1  EX stage holds a live instruction
- ALUSrc  out  1  0 selects read2, 1 selects imme
- ALUcontrol  out  4  ALU operation code
- data1  out  64  ALU operand 1
- read2  out  64  register operand 2
- imme  out  64  immediate operand
- rd  out  5  destination register, instr[11:7]
- RegWrite, MemRead, MemWrite, MemtoReg, Branch  out  1 each  datapath controls
- branch_type  out  2  00 eq, 01 ne, 10 lt, 11 ge
- illegal  out  1  one-cycle pulse: an undecodable instruction was dropped
- stall_cnt  out  16  saturating count of stalled cycles

Function
REQ-003: The block SHALL register every output; decode-to-EX latency SHALL be exactly one clock edge.
REQ-004: ALUcontrol codes SHALL be: AND 0000, OR 0001, ADD 0010, SLL 0100, SUB 0110, SLT 0111, SGE 1000, XOR 1001.
REQ-005: For R-type (opcode 0110011), the block SHALL decode funct3/funct7 as: 000/0000000 ADD, 000/0100000 SUB, 001 SLL, 010 SLT, 100 XOR, 110 OR, 111 AND; it SHALL set ALUSrc=0 and RegWrite=1.
REQ-006: For I-type ALU instructions (opcode 0010011), the block SHALL decode funct3 as 000 ADD, 001 SLL (requires instr[31:26]=0), 010 SLT, 100 XOR, 110 OR, 111 AND; it SHALL set ALUSrc=1 and RegWrite=1.
REQ-007: For ld (opcode 0000011, funct3 011), the block SHALL set ADD, ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1.
REQ-008: For sd (opcode 0100011, funct3 011), the block SHALL set ADD, ALUSrc=1, MemWrite=1, RegWrite=0.
REQ-009: For branches (opcode 1100011), the block SHALL set Branch=1, ALUSrc=0, RegWrite=0, and decode funct3 as: beq 000 → SUB/00, bne 001 → SUB/01, blt 100 → SLT/10, bge 101 → SGE/11.
REQ-010: Any other opcode/funct combination with id_valid=1 SHALL load a bubble and pulse illegal=1 for one cycle.
REQ-011: A bubble SHALL be: ex_valid=0, all control bits 0, ALUcontrol=0000, branch_type=00, rd=0, data1/read2/imme=0.
REQ-012: When id_valid=0 and stall=0, the block SHALL load a bubble at the next edge.
REQ-013: When stall=1 and flush=0, the block SHALL hold all outputs except illegal (forced 0) and stall_cnt.
REQ-014: When flush=1, the block SHALL load a bubble regardless of stall or id_valid; flush SHALL have priority over stall.
REQ-015: stall_cnt SHALL increment on each edge where stall=1 and flush=0, and SHALL saturate at 0xFFFF.
REQ-016: illegal SHALL only pulse on a cycle that loads new decode, that is, stall=0 and flush=0.

Reset
REQ-017: While rst_n=0, all outputs SHALL be 0 (a bubble, illegal=0, stall_cnt=0), immediately and independently of clk.
REQ-018: A reset asserted mid-stall SHALL clear the held instruction and stall_cnt; the first edge after release SHALL decode normally.

Verification
REQ-019: add x3,x1,x2 (0x002081B3) with data1_in=5, read2_in=7 → next edge: ALUcontrol=0010, ALUSrc=0, RegWrite=1, rd=3, data1=5, read2=7, ex_valid=1.
REQ-020: bne (funct3 001) → SUB, Branch=1, branch_type=01; ld → ADD, ALUSrc=1, MemRead=1, MemtoReg=1.
REQ-021: Load sub, then hold stall=1 for 3 cycles with a different instr → outputs unchanged, stall_cnt=3.
REQ-022: stall=1 and flush=1 together → bubble next edge, stall_cnt unchanged.
REQ-023: opcode 1111111 with id_valid=1 → illegal=1 for exactly one cycle, ex_valid=0.
REQ-024: Assert rst_n=0 between clock edges while ex_valid=1 → all outputs 0 before the next edge.
